data_mem_arbiter: RTL
=====================

// Module: data_mem_arbiter
// PURPOSE
//  Two-port request/acknowledge arbiter in front of the single-ported data_mem.
//  Port 0 is the CPU load/store path. Port 1 is a loader/DMA master.
//  Serialises both ports onto data_mem's address/write_data/mem_read/mem_write
//  pins with round-robin fairness. Returns registered read data and per-port
//  error flags.
// PARAMETERS
//  DATA_W      32  word width, equal to the data_mem word width
//  ADDR_W      32  requester address width
//  MEM_ADDR_W  16  implemented byte-address bits; higher bits must be zero
// PORTS
//  clk         in   1       single clock, rising edge
//  rst         in   1       asynchronous, active-high reset
//  req0/req1   in   1       access request; held high until matching ack
//  we0/we1     in   1       1 = write, 0 = read; stable while req high
//  addr0/addr1 in   ADDR_W  byte address, big-endian word at addr..addr+3
//  wdata0/1    in   DATA_W  write data
//  lock0/lock1 in   1       bus-lock request; used only with ARB_LOCK_EN
//  ack0/ack1   out  1       one-cycle completion pulse
//  err0/err1   out  1       valid with ack: access rejected
//  rdata0/1    out  DATA_W  read data; valid with ack, else holds last value
//  address     out  ADDR_W  to data_mem
//  write_data  out  DATA_W  to data_mem
//  mem_read    out  1       to data_mem
//  mem_write   out  1       to data_mem
//  read_data   in   DATA_W  from data_mem (combinational, Z when mem_read=0)
// BEHAVIOUR
//  Reset (async):
//   - state=IDLE, last_owner=1, all mem_* outputs 0, acks/errs 0, rdata 0.
//   - Reset mid-ACCESS drops mem_write at once; the in-flight write does not
//     commit and no ack is issued.
//  FSM: IDLE -> ACCESS -> RESP -> IDLE.
//   - 3 cycles per access. At most one access is outstanding.
//  IDLE:
//   - If any req is high, pick the owner:
//     - only one req high: that port;
//     - both high: the port != last_owner.
//   - Capture owner's addr/wdata/we into registers; last_owner <= owner.
//   - Go to ACCESS.
//   - With no req: stay in IDLE, mem_* = 0.
//  ACCESS:
//   - Drive address/write_data from the captured registers.
//   - mem_write = we and mem_read = !we; the write commits at the edge ending
//     ACCESS.
//   - On that edge, rdata_owner <= read_data for reads.
//   - Bad access: captured addr[1:0]!=0 or addr[ADDR_W-1:MEM_ADDR_W]!=0.
//     - mem_read = mem_write = 0.
//     - Flag error; rdata_owner <= 0.
//  RESP:
//   - ack_owner=1 and err_owner=flag, for this cycle only; mem_* = 0.
//   - Always go to IDLE. The requester drops req on the edge ending RESP, so
//     it is never re-granted for the same request.
//  Non-owner req stays pending; it wins the next IDLE if still high.
//  Outputs mem_* are registered from state/captured regs: no combinational
//  path from req to the memory pins.
//  Bad access takes the same 3 cycles as a good one.
// CONFIGURATION
//  ARB_LOCK_EN defined:
//   - If lock_owner=1 during RESP, set locked=1 and lock_port=owner.
//   - While locked, IDLE grants only lock_port; the other req waits.
//   - locked clears in IDLE when lock_port's lock=0; that IDLE arbitrates
//     normally.
//   - Reset clears locked.
//  ARB_LOCK_EN undefined: lock0/lock1 are ignored; pure round-robin.
// TESTING
//  1. req0 write addr=4 wdata=32'h0000FFFF:
//     - mem_write=1 exactly one cycle, ack0 at cycle 3, err0=0.
//     - Then req0 read addr=4: rdata0=32'h0000FFFF with ack0.
//  2. req0 and req1 rise together, both reads:
//     - port0 acked first (last_owner=1 after reset), port1 ack 3 cycles later.
//     - Repeat: grants alternate 0,1,0,1.
//  3. req1 read addr=32'h0000_1002 (misaligned), and addr=32'h0001_0000:
//     - ack1=1, err1=1, rdata1=0, mem_read and mem_write never asserted.
//  4. Assert rst during ACCESS of a write to addr 44, wdata 32'hFFFF0000:
//     - mem_write falls immediately, no ack.
//     - A later read of 44 returns the old contents.
//  5. ARB_LOCK_EN: port1 holds lock1=1 over 3 reads while req0 stays high:
//     - all 3 port1 acks precede ack0.
//     - Without the macro: acks interleave 1,0,1,1.
//  6. Idle 20 cycles with no req:
//     - mem_read=mem_write=0 throughout, read_data stays Z, no ack.

Source files
------------

// File: rtl/data_mem_arbiter_if.sv
// Request/ack bus between the two requesters, the arbiter and the single-ported data_mem.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface data_mem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req0, req1;
  logic              we0, we1;
  logic              lock0, lock1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic              err0, err1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic              mem_read, mem_write;
  logic [DATA_W-1:0] read_data;

  modport slave (
    input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, read_data,
    output ack0, ack1, err0, err1, rdata0, rdata1, address, write_data, mem_read, mem_write
  );

  modport master (
    output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, read_data,
    input  ack0, ack1, err0, err1, rdata0, rdata1, address, write_data, mem_read, mem_write
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin two-port arbiter serialising requests onto single-ported data_mem (IDLE/ACCESS/RESP).
// Define ARB_LOCK_EN to let the current owner hold the bus across requests via lock0/lock1.
module data_mem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int MEM_ADDR_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  data_mem_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_last_owner, r_owner, r_bad;
  logic [ADDR_W-1:0] r_address, w_address_nxt;
  logic [DATA_W-1:0] r_write_data, w_write_data_nxt;
  logic              r_mem_read, r_mem_write, w_mem_read_nxt, w_mem_write_nxt;
  logic              r_ack0, r_ack1, r_err0, r_err1;
  logic [DATA_W-1:0] r_rdata0, r_rdata1;
  logic              w_grant, w_gnt_port, w_lock_hold, w_lock_port;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_sel_we, w_sel_bad;

  assign w_sel_addr  = w_gnt_port ? bus.addr1  : bus.addr0;
  assign w_sel_wdata = w_gnt_port ? bus.wdata1 : bus.wdata0;
  assign w_sel_we    = w_gnt_port ? bus.we1    : bus.we0;
  assign w_sel_bad   = (w_sel_addr[1:0] != 2'b00) || (w_sel_addr[ADDR_W-1:MEM_ADDR_W] != '0);

`ifdef ARB_LOCK_EN
  logic r_locked, r_lock_port, w_owner_lock;
  assign w_owner_lock = r_owner ? bus.lock1 : bus.lock0;
  assign w_lock_hold  = r_locked && (r_lock_port ? bus.lock1 : bus.lock0);
  assign w_lock_port  = r_lock_port;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_locked    <= 1'b0;
      r_lock_port <= 1'b0;
    end else if (r_state == S_RESP && w_owner_lock) begin
      r_locked    <= 1'b1;
      r_lock_port <= r_owner;
    end else if (r_state == S_IDLE && r_locked && !w_lock_hold) begin
      r_locked    <= 1'b0;
    end
  end
`else
  assign w_lock_hold = 1'b0;
  assign w_lock_port = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_owner <= 1'b1;
      r_owner      <= 1'b0;
      r_bad        <= 1'b0;
      r_address    <= '0;
      r_write_data <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_err0       <= 1'b0;
      r_err1       <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_address    <= w_address_nxt;
      r_write_data <= w_write_data_nxt;
      r_mem_read   <= w_mem_read_nxt;
      r_mem_write  <= w_mem_write_nxt;
      r_ack0       <= (r_state == S_ACCESS) && !r_owner;
      r_ack1       <= (r_state == S_ACCESS) && r_owner;
      r_err0       <= (r_state == S_ACCESS) && !r_owner && r_bad;
      r_err1       <= (r_state == S_ACCESS) && r_owner && r_bad;
      if (w_grant) begin
        r_owner      <= w_gnt_port;
        r_last_owner <= w_gnt_port;
        r_bad        <= w_sel_bad;
      end
      // mem_read is only ever high during a good read, so it doubles as the capture enable
      if (r_state == S_ACCESS) begin
        if (r_bad) begin
          if (r_owner) r_rdata1 <= '0;
          else         r_rdata0 <= '0;
        end else if (r_mem_read) begin
          if (r_owner) r_rdata1 <= bus.read_data;
          else         r_rdata0 <= bus.read_data;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_gnt_port  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_lock_hold) begin
          w_gnt_port = w_lock_port;
          w_grant    = w_lock_port ? bus.req1 : bus.req0;
        end else if (bus.req0 && bus.req1) begin
          w_grant    = 1'b1;
          w_gnt_port = ~r_last_owner;
        end else if (bus.req0 || bus.req1) begin
          w_grant    = 1'b1;
          w_gnt_port = bus.req1;
        end
        if (w_grant) w_state_nxt = S_ACCESS;
      end
      S_ACCESS: w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_address_nxt    = '0;
    w_write_data_nxt = '0;
    w_mem_read_nxt   = 1'b0;
    w_mem_write_nxt  = 1'b0;
    if (r_state == S_IDLE && w_grant) begin
      w_address_nxt    = w_sel_addr;
      w_write_data_nxt = w_sel_wdata;
      w_mem_read_nxt   = !w_sel_we && !w_sel_bad;
      w_mem_write_nxt  = w_sel_we && !w_sel_bad;
    end
  end

  assign bus.address    = r_address;
  assign bus.write_data = r_write_data;
  assign bus.mem_read   = r_mem_read;
  assign bus.mem_write  = r_mem_write;
  assign bus.ack0       = r_ack0;
  assign bus.ack1       = r_ack1;
  assign bus.err0       = r_err0;
  assign bus.err1       = r_err1;
  assign bus.rdata0     = r_rdata0;
  assign bus.rdata1     = r_rdata1;
endmodule
